shot_turn_sequencer: RTL

Two-player shot/turn controller for the billiard game. It arms and fires the cue, waits for the table to settle, and reads which balls left play from the collision controller's `balls_in_game` vector. It then updates scores, switches players, requests a white-ball respawn and declares game over. It sits between the user-input logic and the ball movement/collision datapath, and sequences one shot at a time.

---
 rtl/game_pkg.sv | 28 ++
 rtl/motion_settle_detector.sv | 53 +++++
 rtl/shot_turn_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared billiard-game definitions: turn FSM states, score width, ball count
// and a population-count helper.
package game_pkg;

  // Highest ball index; bit 0 of every ball vector is the white ball.
  localparam int unsigned NUM_BALLS = 2;
  localparam int unsigned SCORE_W   = 4;
  localparam int unsigned POP_W     = 16;

  typedef enum logic [2:0] {
    S_AIM,
    S_FIRE,
    S_ROLL,
    S_EVAL,
    S_OVER
  } turn_state_t;

  // Number of set bits in a zero-extended ball vector.
  function automatic logic [4:0] popcount(input logic [POP_W-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      c = c + {4'b0000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/motion_settle_detector.sv
// Counts frames during a shot; flags when the table has been motionless for
// SETTLE_FRAMES consecutive frames or the shot has run MAX_ROLL_FRAMES frames.
module motion_settle_detector import game_pkg::*; #(
  parameter int unsigned NUM_BALLS       = game_pkg::NUM_BALLS,
  parameter int unsigned SETTLE_FRAMES   = 4,
  parameter int unsigned MAX_ROLL_FRAMES = 600
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               clear,
  input  logic               startOfFrame,
  input  logic [NUM_BALLS:0] motion,
  output logic               settled,
  output logic               timeout
);

  localparam int unsigned RW = $clog2(MAX_ROLL_FRAMES + 1);
  localparam int unsigned SW = $clog2(SETTLE_FRAMES + 1);
  localparam logic [RW-1:0] ROLL_MAX   = RW'(MAX_ROLL_FRAMES);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_FRAMES);

  logic [RW-1:0] roll_cnt;
  logic [SW-1:0] settle_cnt;

  // Per-frame roll and settle counters; both hold at their limits.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      roll_cnt   <= '0;
      settle_cnt <= '0;
    end else if (clear) begin
      roll_cnt   <= '0;
      settle_cnt <= '0;
    end else if (startOfFrame) begin
      if (roll_cnt != ROLL_MAX) begin
        roll_cnt <= roll_cnt + RW'(1);
      end
      if (motion == '0) begin
        if (settle_cnt != SETTLE_MAX) begin
          settle_cnt <= settle_cnt + SW'(1);
        end
      end else begin
        settle_cnt <= '0;
      end
    end
  end

  // Limit decode from the counter registers.
  always_comb begin
    settled = (settle_cnt == SETTLE_MAX);
    timeout = (roll_cnt == ROLL_MAX);
  end

endmodule

// File: rtl/shot_turn_sequencer.sv
// Two-player shot/turn controller: arms and fires the cue, waits for the
// table to settle, scores pocketed balls, switches turns and ends the game.
module shot_turn_sequencer import game_pkg::*; #(
  parameter int unsigned NUM_BALLS       = game_pkg::NUM_BALLS,
  parameter int unsigned SETTLE_FRAMES   = 4,
  parameter int unsigned MAX_ROLL_FRAMES = 600
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               shot_key,
  input  logic               new_game,
  input  logic [NUM_BALLS:0] balls_in_game,
  input  logic [NUM_BALLS:0] balls_moving,
  output logic               shot_enable,
  output logic               fire,
  output logic               white_respawn,
  output logic               rack,
  output logic               current_player,
  output logic [SCORE_W-1:0] score_p0,
  output logic [SCORE_W-1:0] score_p1,
  output logic               game_over,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  turn_state_t        state;
  logic [NUM_BALLS:0] pre_shot;
  logic               key_q;
  logic               key_rise;
  logic [NUM_BALLS:0] motion;
  logic               det_clear;
  logic               det_frame;
  logic               settled;
  logic               timeout;
  logic [NUM_BALLS:0] pocketed;
  logic [POP_W-1:0]   obj_vec;
  logic [4:0]         pot_cnt;
  logic [5:0]         sum;
  logic [SCORE_W-1:0] sat_score;
  logic [SCORE_W-1:0] nxt_p0;
  logic [SCORE_W-1:0] nxt_p1;
  logic               toggle;
  logic               all_cleared;

  // Pocketed balls stop counting as moving, so they never block settling.
  always_comb begin
    motion    = balls_moving & balls_in_game;
    det_clear = (state == S_FIRE);
    det_frame = startOfFrame && (state == S_ROLL);
  end

  motion_settle_detector #(
    .NUM_BALLS       (NUM_BALLS),
    .SETTLE_FRAMES   (SETTLE_FRAMES),
    .MAX_ROLL_FRAMES (MAX_ROLL_FRAMES)
  ) u_settle (
    .clk          (clk),
    .resetN       (resetN),
    .clear        (det_clear),
    .startOfFrame (det_frame),
    .motion       (motion),
    .settled      (settled),
    .timeout      (timeout)
  );

  // Registered shoot-key rising edge; consumed one cycle after sampling.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_q    <= 1'b0;
      key_rise <= 1'b0;
    end else begin
      key_q    <= shot_key;
      key_rise <= shot_key & ~key_q;
    end
  end

  // Shot outcome: saturating score update, turn switch and end-of-game test.
  always_comb begin
    pocketed                 = pre_shot & ~balls_in_game;
    obj_vec                  = '0;
    obj_vec[NUM_BALLS-1:0]   = pocketed[NUM_BALLS:1];
    pot_cnt                  = popcount(obj_vec);
    sum                      = current_player ? 6'(score_p1) + 6'(pot_cnt)
                                              : 6'(score_p0) + 6'(pot_cnt);
    sat_score                = (sum > 6'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
    nxt_p0                   = score_p0;
    nxt_p1                   = score_p1;
    if (!pocketed[0] && (pot_cnt != '0)) begin
      if (current_player) begin
        nxt_p1 = sat_score;
      end else begin
        nxt_p0 = sat_score;
      end
    end
    toggle      = pocketed[0] || (pot_cnt == '0);
    all_cleared = (balls_in_game[NUM_BALLS:1] == '0);
  end

  // Turn FSM with registered outputs, scores and pre-shot snapshot.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= S_AIM;
      shot_enable    <= 1'b1;
      fire           <= 1'b0;
      white_respawn  <= 1'b0;
      rack           <= 1'b0;
      game_over      <= 1'b0;
      winner         <= 1'b0;
      current_player <= 1'b0;
      score_p0       <= '0;
      score_p1       <= '0;
      pre_shot       <= '1;
    end else begin
      fire          <= 1'b0;
      white_respawn <= 1'b0;
      rack          <= 1'b0;
      case (state)
        S_AIM: begin
          if (key_rise) begin
            pre_shot    <= balls_in_game;
            fire        <= 1'b1;
            shot_enable <= 1'b0;
            state       <= S_FIRE;
          end
        end
        S_FIRE: begin
          state <= S_ROLL;
        end
        S_ROLL: begin
          if (settled || timeout) begin
            state <= S_EVAL;
          end
        end
        S_EVAL: begin
          score_p0      <= nxt_p0;
          score_p1      <= nxt_p1;
          white_respawn <= pocketed[0];
          if (toggle) begin
            current_player <= ~current_player;
          end
          if (all_cleared) begin
            game_over <= 1'b1;
            winner    <= (nxt_p1 > nxt_p0);
            state     <= S_OVER;
          end else begin
            shot_enable <= 1'b1;
            state       <= S_AIM;
          end
        end
        S_OVER: begin
          if (new_game) begin
            rack           <= 1'b1;
            score_p0       <= '0;
            score_p1       <= '0;
            current_player <= 1'b0;
            game_over      <= 1'b0;
            winner         <= 1'b0;
            shot_enable    <= 1'b1;
            state          <= S_AIM;
          end
        end
        default: begin
          shot_enable <= 1'b1;
          state       <= S_AIM;
        end
      endcase
    end
  end

endmodule
